// File: rtl/fir_mc_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed multi-channel FIR.
package fir_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Working width for the rounding/saturation helper. Wide enough that the
  // rounding offset can never overflow any accumulator this block is built with.
  localparam int RS_W = 64;

  typedef struct packed {
    logic            sat;
    logic [RS_W-1:0] y;
  } rs_t;

  // Accumulator width that holds TAPS full-precision products without overflow.
  function automatic int acc_width(input int ipl, input int cel, input int taps);
    return ipl + cel + $clog2(taps);
  endfunction

  // Round half up, arithmetic shift right, then clamp to a signed opl-bit range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                    input int shift,
                                    input int opl);
    rs_t                    res;
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    one = RS_W'(1);
    r   = acc;
    if (shift > 0) begin
      r = r + (one <<< (shift - 1));
    end
    r   = r >>> shift;
    hi  = (one <<< (opl - 1)) - one;
    lo  = -hi - one;
    res.sat = 1'b0;
    res.y   = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.y   = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.y   = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mc_round_sat.sv
// Combinational output stage: rounds, scales and saturates the accumulator.
module fir_mc_round_sat
  import fir_mc_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int OPL   = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OPL-1:0]   y_o,
  output logic                    sat_o
);

  logic signed [RS_W-1:0] acc_ext;
  rs_t                    rs;
  logic                   unused_hi;

  // Sign-extend into the helper's working width and apply round/shift/clamp.
  always_comb begin
    acc_ext   = RS_W'(acc_i);
    rs        = round_sat(acc_ext, SHIFT, OPL);
    y_o       = rs.y[OPL-1:0];
    sat_o     = rs.sat;
    unused_hi = ^rs.y[RS_W-1:OPL];
  end

endmodule

// File: rtl/fir_mc.sv
// Time-multiplexed multi-channel signed FIR with one shared multiplier,
// per-channel delay lines and run-time writable shared coefficients.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a sample; coefficient writes accepted here only
//   MAC     | one multiply-accumulate per cycle, tap index k = 0..TAPS-1
//   OUT     | register rounded/saturated result, pulse out_valid
module fir_mc
  import fir_mc_pkg::*;
#(
  parameter  int IPL   = 8,
  parameter  int CEL   = 8,
  parameter  int OPL   = 16,
  parameter  int TAPS  = 4,
  parameter  int CH    = 2,
  parameter  int SHIFT = 0,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1,
  localparam int KW    = $clog2(TAPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHW-1:0]        in_ch,
  input  logic signed [IPL-1:0] X,
  input  logic                  coef_we,
  input  logic [KW-1:0]         coef_addr,
  input  logic signed [CEL-1:0] coef_data,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_ch,
  output logic signed [OPL-1:0] Y,
  output logic                  Y_sat
);

  localparam int ACC_W = acc_width(IPL, CEL, TAPS);
  localparam int PW    = IPL + CEL;

  state_e                  state_q;
  logic [KW-1:0]           k_q;
  logic [CHW-1:0]          ch_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  logic signed [CEL-1:0]   coef_q [TAPS];
  logic signed [IPL-1:0]   hist_q [CH][TAPS];

  logic                    accept;
  logic                    ch_ok;
  logic                    coef_wr;
  logic signed [PW-1:0]    prod;
  logic signed [OPL-1:0]   y_next;
  logic                    sat_next;

  // Ready only in IDLE and never while reset is held, so the front-end sees
  // the block become ready on the very first cycle after release.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  // Out-of-range channel tags complete the handshake but are otherwise ignored.
  assign ch_ok    = (int'(in_ch) < CH);
  assign coef_wr  = coef_we && (state_q == ST_IDLE) && (int'(coef_addr) < TAPS);

  // Single shared multiplier feeding the full-precision accumulator.
  always_comb begin
    prod  = PW'(coef_q[k_q]) * PW'(hist_q[ch_q][k_q]);
    acc_d = acc_q + ACC_W'(prod);
  end

  fir_mc_round_sat #(
    .ACC_W (ACC_W),
    .OPL   (OPL),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc_i (acc_q),
    .y_o   (y_next),
    .sat_o (sat_next)
  );

  // Sequencer: accept, run TAPS MAC cycles, then register the output sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      Y         <= '0;
      Y_sat     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && ch_ok) begin
            ch_q    <= in_ch;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          k_q   <= k_q + 1'b1;
          if (k_q == KW'(TAPS - 1)) begin
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          Y         <= y_next;
          Y_sat     <= sat_next;
          out_ch    <= ch_q;
          out_valid <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Coefficient register file; writes outside IDLE or past the last tap are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= '0;
      end
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Per-channel delay lines; the accepted sample becomes x[0] of its channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          hist_q[c][k] <= '0;
        end
      end
    end else if (accept && ch_ok) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        hist_q[in_ch][k] <= hist_q[in_ch][k-1];
      end
      hist_q[in_ch][0] <= X;
    end
  end

endmodule

// File: doc/fir_mc.md
# fir_mc

Time-multiplexed, multi-channel, signed FIR filter. It is the parametrised successor to the team's single-channel fully parallel FIR. One shared multiplier runs TAPS multiply-accumulate cycles per accepted sample, and each channel keeps its own delay line. Coefficients are run-time writable, and the output is rounded, scaled and saturated. It sits between the sample front-end (valid/ready source) and downstream DSP that consumes tagged output samples.

## Interface
- IPL, 8: input sample width, signed two's complement
- CEL, 8: coefficient width, signed
- OPL, 16: output width, signed
- TAPS, 4: filter length (≥2)
- CH, 2: number of independent channels (≥1)
- SHIFT, 0: arithmetic right shift applied before saturation (0..ACC_W-1)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample this cycle
- in_ch  in  max(1,clog2(CH))  channel tag of offered sample
- X  in  IPL  input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  tap index k (c[k] multiplies x[n-k])
- coef_data  in  CEL  coefficient value
- out_valid  out  1  one-cycle pulse: Y/out_ch/Y_sat valid
- out_ch  out  max(1,clog2(CH))  channel of result
- Y  out  OPL  filtered sample
- Y_sat  out  1  result was clamped

## Operation
- Accumulator width ACC_W = IPL+CEL+clog2(TAPS). All products and sums are signed at full precision, so the accumulator never overflows internally.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, shift X into delay line of in_ch (x[0]←X, x[k]←x[k-1]), latch channel, clear acc and k, then go to MAC.
  - MAC: acc += c[k]*x_ch[k] and k++ every cycle. After k=TAPS-1, go to OUT.
  - OUT: result = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, clamped to [-2^(OPL-1), 2^(OPL-1)-1]. Register Y, out_ch, Y_sat, pulse out_valid, then go to IDLE.
- in_ch ≥ CH: the sample is accepted (handshake completes), no delay line changes, no output is produced, and the FSM stays in IDLE.
- Coefficient writes take effect only in IDLE. coef_we in MAC/OUT is dropped. If coef_addr ≥ TAPS, the write is dropped.
- If coef_we and the sample handshake occur in the same IDLE cycle, the write lands first and the new coefficient is used for that sample.
- Coefficients are shared by all channels.
- Y and out_ch hold their last values between pulses. Y_sat holds too.

## Timing
- Reset values:
  - in_ready=0 while rst is high, 1 on the first cycle after release
  - out_valid=0, Y=0, out_ch=0, Y_sat=0
  - all coefficients=0, all delay lines=0, FSM=IDLE, acc=0
- Latency: if a sample is accepted at edge E0, out_valid is high in the cycle following edge E0+TAPS+1.
- Throughput: one sample per TAPS+2 cycles. in_ready is low for TAPS+1 cycles after each accept.
- Handshake: X, in_ch and in_valid must stay stable until in_ready is seen. No output backpressure exists, and the consumer must accept every out_valid.
- Reset mid-operation (any state): the computation is abandoned, no out_valid is issued, and coefficients and history are cleared.

## Structure
- Package fir_mc_pkg holds:
  - the state enum (IDLE, MAC, OUT)
  - an ACC_W computation function
  - the round/shift/saturate function, parameterised by ACC_W, OPL and SHIFT
- Sub-module fir_mc_round_sat is purely combinational. It takes acc and produces Y_next and sat_next, and is instantiated once in OUT-path logic.
- Top level holds the FSM, the coefficient register file, the CH×TAPS delay-line storage and the single MAC.

## Test plan
All scenarios use defaults unless stated.
- Impulse: coefs {1,2,3,4}; ch0 samples 1,0,0,0 → Y=1,2,3,4 with out_ch=0, each pulse exactly 5 cycles after its accept edge, Y_sat=0.
- Channel isolation: coefs {1,2,3,4}; ch0←10, ch1←5, ch0←0 → outputs (ch0,10), (ch1,5), (ch0,20).
- Saturation: all coefs 127, four samples of 127 → final Y=32767, Y_sat=1. With all coefs -128 and samples 127 → Y=-32768, Y_sat=1.
- Rounding with SHIFT=2: coefs {1,0,0,0}. X=6 → Y=2. X=-6 → Y=-1. X=5 → Y=1.
- Backpressure and coefficient writes: in_valid held high on ch0 → accepts spaced exactly 6 cycles apart with no sample lost. coef_we pulsed during MAC → stored coefficient unchanged. coef_we coincident with the IDLE accept → new value used in that output.
- Reset mid-MAC: assert rst 2 cycles after an accept → no out_valid. After release, a sample of 7 on ch0 yields Y=0 because coefficients are cleared. Reloading coefs {1,0,0,0} and sending 7 yields Y=7.
